// File: rtl/hp_class.sv
// Registered binary16 classifier/unpacker: one-hot class flags, unbiased exponent and
// an 11-bit significand with explicit leading bit, normalized for subnormals.
module hp_class (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        f,
    output logic               snan,
    output logic               qnan,
    output logic               inf,
    output logic               zero,
    output logic               normal,
    output logic               subnormal,
    output logic signed [6:0]  fExp,
    output logic [10:0]        fSig
);

    logic [4:0]  exp_field;
    logic [9:0]  man;
    logic        exp_max;
    logic        exp_min;
    logic        man_nz;

    assign exp_field = f[14:10];
    assign man       = f[9:0];
    assign exp_max   = &exp_field;
    assign exp_min   = ~|exp_field;
    assign man_nz    = |man;

    logic is_snan;
    logic is_qnan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
    logic is_norm;

    assign is_snan = exp_max & man_nz & ~man[9];
    assign is_qnan = exp_max & man[9];
    assign is_inf  = exp_max & ~man_nz;
    assign is_zero = exp_min & ~man_nz;
    assign is_sub  = exp_min & man_nz;
    assign is_norm = ~exp_max & ~exp_min;

    // Leading-zero count of {1'b0, man}; 11 only for man == 0, which never reaches the shifter output.
    logic [3:0] lzc;

    always_comb begin
        lzc = 4'd11;
        casez (man)
            10'b1?????????: lzc = 4'd1;
            10'b01????????: lzc = 4'd2;
            10'b001???????: lzc = 4'd3;
            10'b0001??????: lzc = 4'd4;
            10'b00001?????: lzc = 4'd5;
            10'b000001????: lzc = 4'd6;
            10'b0000001???: lzc = 4'd7;
            10'b00000001??: lzc = 4'd8;
            10'b000000001?: lzc = 4'd9;
            10'b0000000001: lzc = 4'd10;
            default:        lzc = 4'd11;
        endcase
    end

    logic [10:0] shift_in;
    logic [10:0] shift_1;
    logic [10:0] shift_2;
    logic [10:0] shift_4;
    logic [10:0] sub_sig;

    assign shift_in = {1'b0, man};
    assign shift_1  = lzc[0] ? {shift_in[9:0], 1'b0} : shift_in;
    assign shift_2  = lzc[1] ? {shift_1[8:0], 2'b00} : shift_1;
    assign shift_4  = lzc[2] ? {shift_2[6:0], 4'h0}  : shift_2;
    assign sub_sig  = lzc[3] ? {shift_4[2:0], 8'h00} : shift_4;

    // 7'd114 is -14 in 7-bit two's complement; subtracting the shift gives -15..-24.
    logic [6:0] sub_exp;
    logic [6:0] norm_exp;

    assign sub_exp  = 7'd114 - {3'd0, lzc};
    assign norm_exp = {2'b00, exp_field} - 7'd15;

    logic [5:0]  next_flags;
    logic [6:0]  next_exp;
    logic [10:0] next_sig;

    always_comb begin
        next_flags = {is_snan, is_qnan, is_inf, is_zero, is_sub, is_norm};
        next_exp   = 7'd16;
        next_sig   = {1'b1, man};
        if (is_norm) begin
            next_exp = norm_exp;
        end else if (is_sub) begin
            next_exp = sub_exp;
            next_sig = sub_sig;
        end else if (is_zero) begin
            next_exp = 7'd114;
            next_sig = 11'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snan      <= 1'b0;
            qnan      <= 1'b0;
            inf       <= 1'b0;
            zero      <= 1'b0;
            subnormal <= 1'b0;
            normal    <= 1'b0;
            fExp      <= 7'sd0;
            fSig      <= 11'd0;
        end else begin
            {snan, qnan, inf, zero, subnormal, normal} <= next_flags;
            fExp <= next_exp;
            fSig <= next_sig;
        end
    end

endmodule

// File: tb/tb_hp_class.sv
// Self-checking bench for hp_class: directed table, exhaustive sweep with class totals,
// pipelining/reset sequences and randomized operands against a behavioural model.
module tb_hp_class;

    typedef struct packed {
        logic [5:0]  flags;
        logic [6:0]  exp;
        logic [10:0] sig;
    } res_t;

    typedef struct {
        logic        rst;
        logic [15:0] f;
        logic [5:0]  flags;
        int          exp;
        logic [10:0] sig;
    } vec_t;

    // flag order: {snan, qnan, inf, zero, subnormal, normal}
    localparam logic [5:0] SNAN = 6'b100000;
    localparam logic [5:0] QNAN = 6'b010000;
    localparam logic [5:0] INF  = 6'b001000;
    localparam logic [5:0] ZERO = 6'b000100;
    localparam logic [5:0] SUB  = 6'b000010;
    localparam logic [5:0] NORM = 6'b000001;
    localparam logic [5:0] NONE = 6'b000000;

    logic               clk = 1'b0;
    logic               rst;
    logic [15:0]        f;
    logic               snan;
    logic               qnan;
    logic               inf;
    logic               zero;
    logic               normal;
    logic               subnormal;
    logic signed [6:0]  fExp;
    logic [10:0]        fSig;

    int checks = 0;
    int passes = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    hp_class dut (
        .clk(clk), .rst(rst), .f(f),
        .snan(snan), .qnan(qnan), .inf(inf), .zero(zero),
        .normal(normal), .subnormal(subnormal),
        .fExp(fExp), .fSig(fSig)
    );

    // Value-level model: normalize a subnormal by doubling until the hidden bit appears.
    function automatic res_t model(input logic [15:0] x);
        int   e = int'(x[14:10]);
        int   m = int'(x[9:0]);
        int   ex;
        int   sg;
        res_t r;
        if (e == 31) begin
            sg = 1024 + m;
            ex = 16;
            if (m == 0)        r.flags = INF;
            else if (m >= 512) r.flags = QNAN;
            else               r.flags = SNAN;
        end else if (e == 0) begin
            if (m == 0) begin
                r.flags = ZERO;
                sg = 0;
                ex = -14;
            end else begin
                r.flags = SUB;
                sg = m;
                ex = -14;
                while (sg < 1024) begin
                    sg = sg * 2;
                    ex = ex - 1;
                end
            end
        end else begin
            r.flags = NORM;
            sg = 1024 + m;
            ex = e - 15;
        end
        r.exp = 7'(ex);
        r.sig = 11'(sg);
        return r;
    endfunction

    task automatic applyStimulus(input logic r, input logic [15:0] x);
        rst = r;
        f   = x;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input res_t want);
        res_t got;
        got = {snan, qnan, inf, zero, subnormal, normal, fExp, fSig};
        checks++;
        if (got === want) passes++;
        else $display("[TB] FAIL %s f=%h: got flags=%b exp=%0d sig=%h, want flags=%b exp=%0d sig=%h",
                      name, f, got.flags, $signed(got.exp), got.sig,
                      want.flags, $signed(want.exp), want.sig);
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        checks++;
        if (got == want) passes++;
        else $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    endtask

    task automatic addVec(input logic r, input logic [15:0] x, input logic [5:0] fl,
                          input int ex, input logic [10:0] sg);
        vec_t v;
        v.rst = r; v.f = x; v.flags = fl; v.exp = ex; v.sig = sg;
        vecs.push_back(v);
    endtask

    int cnt_snan, cnt_qnan, cnt_inf, cnt_zero, cnt_sub, cnt_norm;

    initial begin
        rst = 1'b1;
        f   = 16'h3C00;

        addVec(1'b1, 16'h3C00, NONE,   0, 11'h000);
        addVec(1'b1, 16'h3C00, NONE,   0, 11'h000);
        addVec(1'b0, 16'h3C00, NORM,   0, 11'h400);
        addVec(1'b0, 16'h7C00, INF,   16, 11'h400);
        addVec(1'b0, 16'hFC00, INF,   16, 11'h400);
        addVec(1'b0, 16'h7E00, QNAN,  16, 11'h600);
        addVec(1'b0, 16'h7C01, SNAN,  16, 11'h401);
        addVec(1'b0, 16'hFFFF, QNAN,  16, 11'h7FF);
        addVec(1'b0, 16'h7DFF, SNAN,  16, 11'h5FF);
        addVec(1'b0, 16'h0000, ZERO, -14, 11'h000);
        addVec(1'b0, 16'h8000, ZERO, -14, 11'h000);
        addVec(1'b0, 16'h0001, SUB,  -24, 11'h400);
        addVec(1'b0, 16'h8001, SUB,  -24, 11'h400);
        addVec(1'b0, 16'h0003, SUB,  -23, 11'h600);
        addVec(1'b0, 16'h0200, SUB,  -15, 11'h400);
        addVec(1'b0, 16'h03FF, SUB,  -15, 11'h7FE);
        addVec(1'b0, 16'h0400, NORM, -14, 11'h400);
        addVec(1'b0, 16'h7BFF, NORM,  15, 11'h7FF);
        addVec(1'b1, 16'h7BFF, NONE,   0, 11'h000);

        foreach (vecs[i]) begin
            res_t want;
            want.flags = vecs[i].flags;
            want.exp   = 7'(vecs[i].exp);
            want.sig   = vecs[i].sig;
            applyStimulus(vecs[i].rst, vecs[i].f);
            checkOutput("directed", want);
        end

        cnt_snan = 0; cnt_qnan = 0; cnt_inf = 0; cnt_zero = 0; cnt_sub = 0; cnt_norm = 0;
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(1'b0, 16'(i));
            checkOutput("sweep", model(16'(i)));
            checks++;
            if ($onehot({snan, qnan, inf, zero, subnormal, normal})) passes++;
            else $display("[TB] FAIL onehot f=%h: got flags=%b, want exactly one set", f,
                          {snan, qnan, inf, zero, subnormal, normal});
            cnt_snan += int'(snan);
            cnt_qnan += int'(qnan);
            cnt_inf  += int'(inf);
            cnt_zero += int'(zero);
            cnt_sub  += int'(subnormal);
            cnt_norm += int'(normal);
        end
        checkCount("total_snan", cnt_snan, 1022);
        checkCount("total_qnan", cnt_qnan, 1024);
        checkCount("total_inf", cnt_inf, 2);
        checkCount("total_zero", cnt_zero, 2);
        checkCount("total_subnormal", cnt_sub, 2046);
        checkCount("total_normal", cnt_norm, 61440);

        // Back-to-back alternation: output holds the previous operand until the next edge.
        applyStimulus(1'b0, 16'h7C01);
        for (int k = 0; k < 10; k++) begin
            logic [15:0] prev;
            logic [15:0] cur;
            prev = (k % 2 == 0) ? 16'h7C01 : 16'h0001;
            cur  = (k % 2 == 0) ? 16'h0001 : 16'h7C01;
            f = cur;
            #1;
            checkOutput("pipe_hold", model(prev));
            @(posedge clk);
            #1;
            checkOutput("pipe_next", model(cur));
        end
        applyStimulus(1'b1, 16'h0001);
        checkOutput("mid_reset", '0);
        applyStimulus(1'b0, 16'h7C01);
        checkOutput("after_reset", model(16'h7C01));

        for (int n = 0; n < 500; n++) begin
            logic [15:0] x;
            logic        r;
            x = 16'($urandom);
            r = ($urandom_range(0, 15) == 0);
            applyStimulus(r, x);
            checkOutput("random", r ? res_t'('0) : model(x));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hp_class.md
# hp_class

Registered classifier and unpacker for IEEE 754 binary16 (half-precision) operands. Each cycle it takes one 16-bit operand and produces a one-hot class flag set: signalling NaN, quiet NaN, infinity, zero, subnormal or normal. It also produces an unbiased signed exponent and an 11-bit significand, normalized for subnormals. It sits at the front of the FPU datapath so downstream arithmetic units receive pre-classified, pre-normalized operands.

## Interface
Parameters: none (format fixed at binary16: 1 sign, 5 exponent, 10 mantissa bits, bias 15).

Ports:
- clk  input  1  – single clock; all state updates on rising edge
- rst  input  1  – synchronous, active-high reset
- f  input  16  – operand; f[15] sign, f[14:10] exponent E, f[9:0] mantissa M
- snan  output  1  – f is a signalling NaN
- qnan  output  1  – f is a quiet NaN
- inf  output  1  – f is ±infinity
- zero  output  1  – f is ±0
- normal  output  1  – f is a normal number
- subnormal  output  1  – f is a subnormal number
- fExp  output  7 (signed, two's complement)  – unbiased exponent
- fSig  output  11  – significand with explicit leading bit

## Operation
Classification (sign f[15] ignored):
- E=31, M≠0, M[9]=0 → snan
- E=31, M[9]=1 → qnan
- E=31, M=0 → inf
- E=0, M=0 → zero
- E=0, M≠0 → subnormal
- 1≤E≤30 → normal
- Exactly one flag is high whenever not in reset.

Unpacking:
- normal: fSig={1'b1,M}, fExp=E−15 (range −14..+15)
- subnormal: s = leading-zero count of {1'b0,M} (1..10). fSig={1'b0,M}<<s, so fSig[10]=1. fExp=−14−s (range −15..−24). Example: M=0x200 → fSig=0x400, fExp=−15. M=0x001 → fSig=0x400, fExp=−24.
- zero: fSig=0, fExp=−14
- inf/snan/qnan: fSig={1'b1,M}, fExp=+16
- The leading-zero count/shift is combinational (priority encoder plus barrel shifter) ahead of the output register.

## Timing
- All outputs are registered. Latency is 1 cycle: values for f sampled at rising edge N are visible after edge N.
- A new operand is accepted every cycle. There is no handshake and no stall.
- Reset: when rst=1 at a rising edge, all six flags=0, fExp=0 and fSig=0 after that edge. rst has priority over f.
- First valid result appears one edge after rst deasserts, using f sampled at that edge.
- Reset asserted mid-stream discards the in-flight result.
- No internal state beyond the output register. Back-to-back operands of any class produce back-to-back results.

## Test plan
- Reset: hold rst=1 with f=0x3C00 → all flags 0, fExp=0, fSig=0. Release rst → next cycle normal=1, fExp=0, fSig=0x400.
- Specials: 0x7C00 and 0xFC00 → inf, fExp=16. 0x7E00 → qnan. 0x7C01 → snan, fSig=0x401. 0x0000 and 0x8000 → zero, fExp=−14, fSig=0.
- Subnormals: 0x0001 → subnormal, fExp=−24, fSig=0x400. 0x0200 → fExp=−15, fSig=0x400. 0x03FF → fExp=−15, fSig=0x7FE.
- Normals: 0x0400 → fExp=−14, fSig=0x400. 0x7BFF → fExp=15, fSig=0x7FF.
- Exhaustive sweep: drive all 65536 codes, one per cycle, and check the one-hot property on each. Required totals: snan 1022, qnan 1024, inf 2, zero 2, subnormal 2046, normal 61440.
- Pipelining: alternate 0x7C01 and 0x0001 every cycle → results alternate snan and subnormal with 1-cycle lag. Assert rst mid-sequence → outputs 0 on the following cycle.
